// File: rtl/multi_tick_generator.sv
// Multi-channel programmable clock-enable generator: per channel a one-cycle Tick every
// div cycles and a 50%-duty Square, with shadowed divisors that switch in at the wrap.
module multi_tick_generator #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned DIV_W       = 26,
    parameter int unsigned DEFAULT_DIV = 25000,
    parameter int unsigned CH_W        = 2
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [NUM_CH-1:0] Enable,
    input  logic              Sync,
    input  logic              Load,
    input  logic [CH_W-1:0]   Load_Ch,
    input  logic [DIV_W-1:0]  Load_Div,
    output logic [NUM_CH-1:0] Tick,
    output logic [NUM_CH-1:0] Square,
    output logic [NUM_CH-1:0] Div_Pending
);

    localparam logic [DIV_W-1:0] DefDiv = DIV_W'(DEFAULT_DIV);

    // A zero divisor would never wrap; it is clamped to 1.
    logic [DIV_W-1:0] load_val;
    assign load_val = (Load_Div == '0) ? DIV_W'(1) : Load_Div;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [DIV_W-1:0] cnt_q, cnt_d;
        logic [DIV_W-1:0] act_q, act_d;
        logic [DIV_W-1:0] shd_q, shd_d;
        logic             tick_q, tick_d;
        logic             sq_q, sq_d;
        logic             pend_q, pend_d;
        logic             load_hit;
        logic             wrap;

        // Out-of-range Load_Ch values match no channel.
        assign load_hit = Load && (Load_Ch == CH_W'(i));
        assign wrap     = (cnt_q == act_q - DIV_W'(1));

        always_comb begin
            cnt_d  = cnt_q;
            act_d  = act_q;
            shd_d  = shd_q;
            tick_d = 1'b0;
            sq_d   = sq_q;
            pend_d = pend_q;
            if (Sync) begin
                cnt_d  = '0;
                sq_d   = 1'b0;
                pend_d = 1'b0;
                act_d  = load_hit ? load_val : shd_q;
                shd_d  = load_hit ? load_val : shd_q;
            end else begin
                if (Enable[i]) begin
                    if (wrap) begin
                        cnt_d  = '0;
                        tick_d = 1'b1;
                        sq_d   = ~sq_q;
                        act_d  = shd_q;
                        pend_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + DIV_W'(1);
                    end
                end
                // Load wins over the wrap clear so the new value stays pending.
                if (load_hit) begin
                    shd_d  = load_val;
                    pend_d = 1'b1;
                end
            end
        end

        always_ff @(posedge Clock) begin
            if (Reset) begin
                cnt_q  <= '0;
                act_q  <= DefDiv;
                shd_q  <= DefDiv;
                tick_q <= 1'b0;
                sq_q   <= 1'b0;
                pend_q <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                act_q  <= act_d;
                shd_q  <= shd_d;
                tick_q <= tick_d;
                sq_q   <= sq_d;
                pend_q <= pend_d;
            end
        end

        assign Tick[i]        = tick_q;
        assign Square[i]      = sq_q;
        assign Div_Pending[i] = pend_q;
    end

endmodule

// File: tb/tb_multi_tick_generator.sv
// Directed bench for multi_tick_generator: vector table for the basic run and divisor
// reload, hand sequences for Sync, Enable gating, reset and out-of-range loads.
module tb_multi_tick_generator;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [3:0]  Enable = 4'h0;
    logic        Sync = 1'b0;
    logic        Load = 1'b0;
    logic [1:0]  Load_Ch = 2'd0;
    logic [25:0] Load_Div = 26'd0;
    logic [3:0]  Tick, Square, Div_Pending;
    logic [2:0]  t3, s3, p3;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 Clock = ~Clock;

    multi_tick_generator #(
        .NUM_CH(4), .DIV_W(26), .DEFAULT_DIV(4), .CH_W(2)
    ) u_dut (
        .Clock(Clock), .Reset(Reset), .Enable(Enable), .Sync(Sync), .Load(Load),
        .Load_Ch(Load_Ch), .Load_Div(Load_Div), .Tick(Tick), .Square(Square),
        .Div_Pending(Div_Pending)
    );

    // Three channels so that Load_Ch=3 is out of range.
    multi_tick_generator #(
        .NUM_CH(3), .DIV_W(26), .DEFAULT_DIV(4), .CH_W(2)
    ) u_dut3 (
        .Clock(Clock), .Reset(Reset), .Enable(Enable[2:0]), .Sync(Sync), .Load(Load),
        .Load_Ch(Load_Ch), .Load_Div(Load_Div), .Tick(t3), .Square(s3),
        .Div_Pending(p3)
    );

    typedef struct {
        logic [3:0]  en;
        logic        load;
        logic [1:0]  ch;
        logic [25:0] dv;
        logic [3:0]  tick;
        logic [3:0]  sq;
        logic [3:0]  pend;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step(input logic [3:0] en, input logic sy, input logic ld,
                        input logic [1:0] ch, input logic [25:0] dv);
        Enable   = en;
        Sync     = sy;
        Load     = ld;
        Load_Ch  = ch;
        Load_Div = dv;
        @(posedge Clock);
        #1;
        Sync = 1'b0;
        Load = 1'b0;
    endtask

    initial begin
        // Period 4 everywhere; ch1 reloaded to 6 at edge 6, switches at its wrap on edge 8.
        vecs[0]  = '{4'hF, 1'b0, 2'd0, 26'd0, 4'h0, 4'h0, 4'h0};
        vecs[1]  = '{4'hF, 1'b0, 2'd0, 26'd0, 4'h0, 4'h0, 4'h0};
        vecs[2]  = '{4'hF, 1'b0, 2'd0, 26'd0, 4'h0, 4'h0, 4'h0};
        vecs[3]  = '{4'hF, 1'b0, 2'd0, 26'd0, 4'hF, 4'hF, 4'h0};
        vecs[4]  = '{4'hF, 1'b0, 2'd0, 26'd0, 4'h0, 4'hF, 4'h0};
        vecs[5]  = '{4'hF, 1'b1, 2'd1, 26'd6, 4'h0, 4'hF, 4'h2};
        vecs[6]  = '{4'hF, 1'b0, 2'd0, 26'd0, 4'h0, 4'hF, 4'h2};
        vecs[7]  = '{4'hF, 1'b0, 2'd0, 26'd0, 4'hF, 4'h0, 4'h0};
        vecs[8]  = '{4'hF, 1'b0, 2'd0, 26'd0, 4'h0, 4'h0, 4'h0};
        vecs[9]  = '{4'hF, 1'b0, 2'd0, 26'd0, 4'h0, 4'h0, 4'h0};
        vecs[10] = '{4'hF, 1'b0, 2'd0, 26'd0, 4'h0, 4'h0, 4'h0};
        vecs[11] = '{4'hF, 1'b0, 2'd0, 26'd0, 4'hD, 4'hD, 4'h0};
        vecs[12] = '{4'hF, 1'b0, 2'd0, 26'd0, 4'h0, 4'hD, 4'h0};
        vecs[13] = '{4'hF, 1'b0, 2'd0, 26'd0, 4'h2, 4'hF, 4'h0};
        vecs[14] = '{4'hF, 1'b0, 2'd0, 26'd0, 4'h0, 4'hF, 4'h0};
        vecs[15] = '{4'hF, 1'b0, 2'd0, 26'd0, 4'hD, 4'h2, 4'h0};

        // Reset state
        Reset = 1'b1;
        step(4'hF, 1'b0, 1'b0, 2'd0, 26'd0);
        step(4'hF, 1'b0, 1'b0, 2'd0, 26'd0);
        check("reset tick", 32'(Tick), 32'h0);
        check("reset square", 32'(Square), 32'h0);
        check("reset pending", 32'(Div_Pending), 32'h0);
        check("reset tick ch3dut", 32'(t3), 32'h0);
        Reset = 1'b0;

        // Basic run and mid-period reload of ch1
        for (int k = 0; k < 16; k++) begin
            step(vecs[k].en, 1'b0, vecs[k].load, vecs[k].ch, vecs[k].dv);
            check($sformatf("vec%0d tick", k), 32'(Tick), 32'(vecs[k].tick));
            check($sformatf("vec%0d square", k), 32'(Square), 32'(vecs[k].sq));
            check($sformatf("vec%0d pending", k), 32'(Div_Pending), 32'(vecs[k].pend));
        end

        // Divisor 0 clamps to 1: after Sync ch2 ticks every cycle
        step(4'hF, 1'b0, 1'b1, 2'd2, 26'd0);
        check("div0 pending", 32'(Div_Pending), 32'h4);
        step(4'hF, 1'b1, 1'b0, 2'd0, 26'd0);
        check("sync tick", 32'(Tick), 32'h0);
        check("sync square", 32'(Square), 32'h0);
        check("sync pending", 32'(Div_Pending), 32'h0);
        for (int k = 0; k < 4; k++) begin
            step(4'hF, 1'b0, 1'b0, 2'd0, 26'd0);
            check($sformatf("div1 tick2 c%0d", k), 32'(Tick[2]), 32'h1);
            check($sformatf("div1 square2 c%0d", k), 32'(Square[2]), 32'((k % 2) == 0));
        end
        // Load coinciding with a wrap stays pending, clears on the following wrap
        step(4'hF, 1'b0, 1'b1, 2'd2, 26'd1);
        check("wrap+load pending", 32'(Div_Pending[2]), 32'h1);
        check("wrap+load tick", 32'(Tick[2]), 32'h1);
        step(4'hF, 1'b0, 1'b0, 2'd0, 26'd0);
        check("wrap clears pending", 32'(Div_Pending[2]), 32'h0);

        // Reset with a pending load discards it
        step(4'hF, 1'b0, 1'b1, 2'd1, 26'd9);
        check("pre-reset pending", 32'(Div_Pending[1]), 32'h1);
        Reset = 1'b1;
        step(4'hF, 1'b0, 1'b0, 2'd0, 26'd0);
        Reset = 1'b0;
        check("midrun reset tick", 32'(Tick), 32'h0);
        check("midrun reset square", 32'(Square), 32'h0);
        check("midrun reset pending", 32'(Div_Pending), 32'h0);

        // Load_Ch=3 is out of range for the 3-channel instance
        step(4'h0, 1'b0, 1'b1, 2'd3, 26'd9);
        check("oor pending ch3dut", 32'(p3), 32'h0);
        check("inrange pending main", 32'(Div_Pending), 32'h8);
        for (int k = 1; k <= 4; k++) step(4'hF, 1'b0, 1'b0, 2'd0, 26'd0);
        check("default restored tick", 32'(Tick), 32'hF);
        check("oor tick ch3dut", 32'(t3), 32'h7);
        check("post-wrap pending", 32'(Div_Pending), 32'h0);
        for (int k = 1; k <= 4; k++) step(4'hF, 1'b0, 1'b0, 2'd0, 26'd0);
        check("oor period ch3dut", 32'(t3), 32'h7);

        // Enable gating with ch0 cnt=2 and Square=0 after two toggles
        step(4'hF, 1'b0, 1'b0, 2'd0, 26'd0);
        step(4'hF, 1'b0, 1'b0, 2'd0, 26'd0);
        for (int k = 0; k < 10; k++) begin
            step(4'hE, 1'b0, 1'b0, 2'd0, 26'd0);
            check($sformatf("disabled tick0 c%0d", k), 32'(Tick[0]), 32'h0);
            check($sformatf("disabled square0 c%0d", k), 32'(Square[0]), 32'h0);
        end
        step(4'hF, 1'b0, 1'b0, 2'd0, 26'd0);
        check("reenable edge1 tick0", 32'(Tick[0]), 32'h0);
        step(4'hF, 1'b0, 1'b0, 2'd0, 26'd0);
        check("reenable edge2 tick0", 32'(Tick[0]), 32'h1);
        check("reenable edge2 square0", 32'(Square[0]), 32'h1);

        // Sync with same-cycle Load: new divisor active at once, nothing pending
        step(4'hF, 1'b1, 1'b1, 2'd3, 26'd8);
        check("sync+load tick", 32'(Tick), 32'h0);
        check("sync+load square", 32'(Square), 32'h0);
        check("sync+load pending", 32'(Div_Pending), 32'h0);
        for (int k = 1; k <= 8; k++) begin
            step(4'hF, 1'b0, 1'b0, 2'd0, 26'd0);
            check($sformatf("div8 tick3 e%0d", k), 32'(Tick[3]), 32'(k == 8));
        end
        check("div8 pending", 32'(Div_Pending), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
